// File: rtl/core_ncache_router.sv
// Routes one upstream request at a time to a cached or uncached port.
// Non-cacheable address regions (base/mask/enable) select the port.
//
// Ports:
//   core_sys_clk / core_sys_rst : single clock, synchronous active-high reset
//   cfg_wr_*    : region register writes (sel 0=base, 1=mask, 2=enable)
//   d_req_* / d_ack_rdata : upstream request, one-cycle ack with read data
//   c_req_* / c_ack_rdata : cached downstream port
//   u_req_* / u_ack_rdata : uncached downstream port
//   err_timeout : pulses with a d_req_ack that was forced by the wait limit
//   stat_nc_cnt : saturating count of requests routed uncached
module core_ncache_router #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NC_REGIONS = 2,
  parameter int TIMEOUT    = 256
) (
  input  logic                  core_sys_clk,
  input  logic                  core_sys_rst,
  input  logic                  cfg_wr_val,
  input  logic [2:0]            cfg_wr_idx,
  input  logic [1:0]            cfg_wr_sel,
  input  logic [ADDR_WIDTH-1:0] cfg_wr_data,
  input  logic                  d_req_val,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic [2:0]            d_req_cop,
  input  logic [DATA_WIDTH-1:0] d_req_wdata,
  input  logic [2:0]            d_req_size,
  output logic                  d_req_ack,
  output logic [DATA_WIDTH-1:0] d_ack_rdata,
  output logic                  c_req_val,
  output logic [ADDR_WIDTH-1:0] c_req_addr,
  output logic [2:0]            c_req_cop,
  output logic [DATA_WIDTH-1:0] c_req_wdata,
  output logic [2:0]            c_req_size,
  input  logic                  c_req_ack,
  input  logic [DATA_WIDTH-1:0] c_ack_rdata,
  output logic                  u_req_val,
  output logic [ADDR_WIDTH-1:0] u_req_addr,
  output logic [2:0]            u_req_cop,
  output logic [DATA_WIDTH-1:0] u_req_wdata,
  output logic [2:0]            u_req_size,
  input  logic                  u_req_ack,
  input  logic [DATA_WIDTH-1:0] u_ack_rdata,
  output logic                  err_timeout,
  output logic [15:0]           stat_nc_cnt
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    C_WAIT,
    U_WAIT,
    RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_WIDTH-1:0] r_base [NC_REGIONS];
  logic [ADDR_WIDTH-1:0] r_mask [NC_REGIONS];
  logic [NC_REGIONS-1:0] r_en;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [2:0]            r_cop;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [2:0]            r_size;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_tmo;
  logic [CW-1:0]         r_cnt;
  logic [15:0]           r_stat;

  logic                  w_nc_hit;
  logic                  w_ack;
  logic [DATA_WIDTH-1:0] w_ack_data;
  logic                  w_limit;

  // Region registers; out-of-range indices match no loop
  // iteration and are dropped.
  always_ff @(posedge core_sys_clk) begin
    if (core_sys_rst) begin
      for (int i = 0; i < NC_REGIONS; i++) begin
        r_base[i] <= '0;
        r_mask[i] <= '0;
      end
      r_en <= '0;
    end else if (cfg_wr_val) begin
      for (int i = 0; i < NC_REGIONS; i++) begin
        if (cfg_wr_idx == 3'(i)) begin
          case (cfg_wr_sel)
            2'd0:    r_base[i] <= cfg_wr_data;
            2'd1:    r_mask[i] <= cfg_wr_data;
            2'd2:    r_en[i]   <= cfg_wr_data[0];
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    w_nc_hit = 1'b0;
    for (int i = 0; i < NC_REGIONS; i++) begin
      if (r_en[i] &&
          ((d_req_addr & ~r_mask[i]) == r_base[i]))
        w_nc_hit = 1'b1;
    end
  end

  // Only the port chosen at classification can complete.
  always_comb begin
    w_ack      = 1'b0;
    w_ack_data = '0;
    if (r_state == C_WAIT) begin
      w_ack      = c_req_ack;
      w_ack_data = c_ack_rdata;
    end else if (r_state == U_WAIT) begin
      w_ack      = u_req_ack;
      w_ack_data = u_ack_rdata;
    end
  end

  assign w_limit = (r_cnt == LIM);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (d_req_val)
          w_next = w_nc_hit ? U_WAIT : C_WAIT;
      end
      C_WAIT, U_WAIT: begin
        if (w_ack || w_limit)
          w_next = RESP;
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge core_sys_clk) begin
    if (core_sys_rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_cop   <= '0;
      r_wdata <= '0;
      r_size  <= '0;
      r_rdata <= '0;
      r_tmo   <= 1'b0;
      r_cnt   <= '0;
      r_stat  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && d_req_val) begin
        r_addr  <= d_req_addr;
        r_cop   <= d_req_cop;
        r_wdata <= d_req_wdata;
        r_size  <= d_req_size;
        r_cnt   <= '0;
        r_tmo   <= 1'b0;
        if (w_nc_hit && r_stat != 16'hFFFF)
          r_stat <= r_stat + 16'd1;
      end else if (r_state == C_WAIT ||
                   r_state == U_WAIT) begin
        // An ack on the limit cycle beats the timeout.
        if (w_ack) begin
          r_rdata <= w_ack_data;
          r_tmo   <= 1'b0;
        end else if (w_limit) begin
          r_rdata <= '0;
          r_tmo   <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign c_req_val   = (r_state == C_WAIT);
  assign u_req_val   = (r_state == U_WAIT);
  assign c_req_addr  = r_addr;
  assign c_req_cop   = r_cop;
  assign c_req_wdata = r_wdata;
  assign c_req_size  = r_size;
  assign u_req_addr  = r_addr;
  assign u_req_cop   = r_cop;
  assign u_req_wdata = r_wdata;
  assign u_req_size  = r_size;

  assign d_req_ack   = (r_state == RESP);
  assign d_ack_rdata = d_req_ack ? r_rdata : '0;
  assign err_timeout = d_req_ack && r_tmo;
  assign stat_nc_cnt = r_stat;

endmodule

// File: tb/tb_core_ncache_router.sv
// Scoreboard bench for core_ncache_router.
// Expected completions are queued at issue and popped on d_req_ack.
module tb_core_ncache_router;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_wr_val;
  logic [2:0]  cfg_wr_idx;
  logic [1:0]  cfg_wr_sel;
  logic [31:0] cfg_wr_data;
  logic        d_req_val;
  logic [31:0] d_req_addr;
  logic [2:0]  d_req_cop;
  logic [31:0] d_req_wdata;
  logic [2:0]  d_req_size;
  logic        d_req_ack;
  logic [31:0] d_ack_rdata;
  logic        c_req_val;
  logic [31:0] c_req_addr;
  logic [2:0]  c_req_cop;
  logic [31:0] c_req_wdata;
  logic [2:0]  c_req_size;
  logic        c_req_ack;
  logic [31:0] c_ack_rdata;
  logic        u_req_val;
  logic [31:0] u_req_addr;
  logic [2:0]  u_req_cop;
  logic [31:0] u_req_wdata;
  logic [2:0]  u_req_size;
  logic        u_req_ack;
  logic [31:0] u_ack_rdata;
  logic        err_timeout;
  logic [15:0] stat_nc_cnt;

  core_ncache_router #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .NC_REGIONS(2),
    .TIMEOUT(8)
  ) dut (
    .core_sys_clk(clk),
    .core_sys_rst(rst),
    .cfg_wr_val(cfg_wr_val),
    .cfg_wr_idx(cfg_wr_idx),
    .cfg_wr_sel(cfg_wr_sel),
    .cfg_wr_data(cfg_wr_data),
    .d_req_val(d_req_val),
    .d_req_addr(d_req_addr),
    .d_req_cop(d_req_cop),
    .d_req_wdata(d_req_wdata),
    .d_req_size(d_req_size),
    .d_req_ack(d_req_ack),
    .d_ack_rdata(d_ack_rdata),
    .c_req_val(c_req_val),
    .c_req_addr(c_req_addr),
    .c_req_cop(c_req_cop),
    .c_req_wdata(c_req_wdata),
    .c_req_size(c_req_size),
    .c_req_ack(c_req_ack),
    .c_ack_rdata(c_ack_rdata),
    .u_req_val(u_req_val),
    .u_req_addr(u_req_addr),
    .u_req_cop(u_req_cop),
    .u_req_wdata(u_req_wdata),
    .u_req_size(u_req_size),
    .u_req_ack(u_req_ack),
    .u_ack_rdata(u_ack_rdata),
    .err_timeout(err_timeout),
    .stat_nc_cnt(stat_nc_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   m_stat = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (err_timeout && !d_req_ack)
      chk("err_spur", 1, 0);
    if (d_req_ack) begin
      if (sb.size() == 0) begin
        chk("sb_unexp_ack", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_rdata", d_ack_rdata, e.rdata);
        chk("sb_err", err_timeout, e.err);
      end
    end
  end

  task automatic cfg_wr(input logic [2:0] idx,
                        input logic [1:0] sel,
                        input logic [31:0] data);
    @(negedge clk);
    cfg_wr_val  = 1'b1;
    cfg_wr_idx  = idx;
    cfg_wr_sel  = sel;
    cfg_wr_data = data;
    @(negedge clk);
    cfg_wr_val  = 1'b0;
  endtask

  task automatic do_req(input logic [31:0] addr,
                        input bit nc,
                        input int dly,
                        input logic [31:0] rd,
                        input bit noack,
                        input bit wrong,
                        input bit cfgmid);
    logic [2:0]  cop;
    logic [2:0]  sz;
    logic [31:0] wd;
    int k;
    cop = 3'($urandom);
    sz  = 3'($urandom);
    wd  = $urandom;
    @(negedge clk);
    d_req_val   = 1'b1;
    d_req_addr  = addr;
    d_req_cop   = cop;
    d_req_wdata = wd;
    d_req_size  = sz;
    sb.push_back('{noack ? 32'h0 : rd, noack});
    if (nc) m_stat++;
    @(negedge clk);
    d_req_val = 1'b0;
    chk("route_u", u_req_val, nc);
    chk("route_c", c_req_val, !nc);
    chk("p_addr", nc ? u_req_addr : c_req_addr, addr);
    chk("p_cop", nc ? u_req_cop : c_req_cop, cop);
    chk("p_wdata", nc ? u_req_wdata : c_req_wdata, wd);
    chk("p_size", nc ? u_req_size : c_req_size, sz);
    if (wrong) begin
      if (nc) begin
        c_req_ack = 1'b1; c_ack_rdata = ~rd;
      end else begin
        u_req_ack = 1'b1; u_ack_rdata = ~rd;
      end
    end
    if (cfgmid) begin
      cfg_wr_val  = 1'b1;
      cfg_wr_idx  = 3'd1;
      cfg_wr_sel  = 2'd2;
      cfg_wr_data = 32'h0;
    end
    if (noack) begin
      k = 0;
      for (int j = 1; j <= 20; j++) begin
        @(negedge clk);
        c_req_ack = 1'b0;
        u_req_ack = 1'b0;
        cfg_wr_val = 1'b0;
        k = j;
        if (d_req_ack) break;
      end
      chk("tmo_lat", k, 8);
      chk("tmo_err", err_timeout, 1);
      if (nc) u_req_ack = 1'b1;
      else    c_req_ack = 1'b1;
      u_ack_rdata = 32'hDEAD_0001;
      c_ack_rdata = 32'hDEAD_0001;
      @(negedge clk);
      chk("late_ack1", d_req_ack, 0);
      @(negedge clk);
      u_req_ack = 1'b0;
      c_req_ack = 1'b0;
      chk("late_ack2", d_req_ack, 0);
      @(negedge clk);
      chk("late_ack3", d_req_ack, 0);
    end else begin
      for (int j = 0; j < dly; j++) begin
        @(negedge clk);
        c_req_ack = 1'b0;
        u_req_ack = 1'b0;
        cfg_wr_val = 1'b0;
      end
      chk("wait_sel", nc ? u_req_val : c_req_val, 1);
      chk("wait_oth", nc ? c_req_val : u_req_val, 0);
      chk("wait_noack", d_req_ack, 0);
      if (nc) begin
        u_req_ack = 1'b1; u_ack_rdata = rd;
      end else begin
        c_req_ack = 1'b1; c_ack_rdata = rd;
      end
      @(negedge clk);
      u_req_ack = 1'b0;
      c_req_ack = 1'b0;
      u_ack_rdata = $urandom;
      c_ack_rdata = $urandom;
      chk("ack_lat", d_req_ack, 1);
      chk("ack_err0", err_timeout, 0);
      chk("val_drop", c_req_val | u_req_val, 0);
      @(negedge clk);
      chk("ack_1cyc", d_req_ack, 0);
    end
    chk("stat", stat_nc_cnt, 16'(m_stat));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    cfg_wr_val = 1'b0;
    cfg_wr_idx = '0;
    cfg_wr_sel = '0;
    cfg_wr_data = '0;
    d_req_val = 1'b1;
    d_req_addr = 32'h8000_0000;
    d_req_cop = 3'd1;
    d_req_wdata = 32'h1;
    d_req_size = 3'd2;
    c_req_ack = 1'b1;
    c_ack_rdata = 32'h5;
    u_req_ack = 1'b1;
    u_ack_rdata = 32'h5;
    repeat (3) @(negedge clk);
    chk("rst_cval", c_req_val, 0);
    chk("rst_uval", u_req_val, 0);
    chk("rst_dack", d_req_ack, 0);
    chk("rst_rdata", d_ack_rdata, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_stat", stat_nc_cnt, 0);
    chk("rst_addr", c_req_addr, 0);
    d_req_val = 1'b0;
    c_req_ack = 1'b0;
    u_req_ack = 1'b0;
    rst = 1'b0;

    do_req(32'h8000_0000, 0, 2, 32'h1234_5678, 0, 0, 0);

    cfg_wr(3'd0, 2'd0, 32'h8000_0000);
    cfg_wr(3'd0, 2'd1, 32'h0000_FFFF);
    cfg_wr(3'd0, 2'd2, 32'h1);
    do_req(32'h8000_00F0, 1, 1, 32'hA5A5_0001, 0, 0, 0);
    do_req(32'h8001_0000, 0, 3, 32'hA5A5_0002, 0, 1, 0);

    cfg_wr(3'd0, 2'd2, 32'h0);
    cfg_wr(3'd1, 2'd0, 32'h4000_0000);
    cfg_wr(3'd1, 2'd1, 32'h0FFF_FFFF);
    cfg_wr(3'd1, 2'd2, 32'h1);
    do_req(32'h4123_4560, 1, 0, 32'hA5A5_0003, 0, 0, 0);
    do_req(32'h8000_00F0, 0, 1, 32'hA5A5_0004, 0, 0, 0);

    cfg_wr(3'd5, 2'd2, 32'h0);
    cfg_wr(3'd1, 2'd3, 32'h0);
    cfg_wr(3'd7, 2'd0, 32'hFFFF_FFFF);
    do_req(32'h4000_0010, 1, 1, 32'hA5A5_0005, 0, 1, 0);

    do_req(32'h4000_0020, 1, 0, 32'h0, 1, 0, 0);
    do_req(32'h4000_0030, 1, 7, 32'hBEEF_0007, 0, 0, 0);
    do_req(32'h8000_0040, 0, 0, 32'h0, 1, 0, 0);

    do_req(32'h4000_0040, 1, 2, 32'hA5A5_0006, 0, 0, 1);
    do_req(32'h4000_0040, 0, 1, 32'hA5A5_0007, 0, 0, 0);

    cfg_wr(3'd1, 2'd2, 32'h1);
    @(negedge clk);
    d_req_val  = 1'b1;
    d_req_addr = 32'h4000_0050;
    @(negedge clk);
    d_req_val = 1'b0;
    chk("prerst_uval", u_req_val, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_stat = 0;
    chk("mrst_uval", u_req_val, 0);
    chk("mrst_dack", d_req_ack, 0);
    chk("mrst_stat", stat_nc_cnt, 0);
    chk("mrst_addr", u_req_addr, 0);
    u_req_ack = 1'b1;
    u_ack_rdata = 32'hDEAD_0002;
    @(negedge clk);
    u_req_ack = 1'b0;
    chk("mrst_late1", d_req_ack, 0);
    @(negedge clk);
    chk("mrst_late2", d_req_ack, 0);
    do_req(32'h4000_0050, 0, 1, 32'hA5A5_0008, 0, 0, 0);
    do_req(32'h8000_00F0, 0, 0, 32'hA5A5_0009, 0, 0, 0);

    for (int i = 0; i < 6; i++) begin
      do_req($urandom, 0, $urandom_range(0, 4),
             $urandom, 0, 0, 0);
    end

    repeat (3) @(negedge clk);
    chk("sb_left", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
